modular_inverse: RTL

//  Computes o_result = i_a^-1 mod i_n for odd i_n with a binary extended-Euclid FSM.

---
 rtl/modular_inverse.sv | 139 +++++++++++++
 1 files changed

// File: rtl/modular_inverse.sv
// Modular inverse o_result = i_a^-1 mod i_n (i_n odd), using a binary
// extended-Euclid state machine that performs one update step per clock.
// It shares its start/finished handshake with the ECC modular multiplier.
// Optional build macro: MODINV_ITER_LIMIT_EN adds a RUN cycle limit that
// ends a run with an error if it ever exceeds 4*WIDTH+4 cycles.
module modular_inverse #(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finished,
    output logic             o_error,
    output logic             o_busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] u, v, x1, x2, n_q, res_q;
    logic             err_q;

    logic [WIDTH:0]   x1_sum, x2_sum, x1_half, x2_half, x1_diff, x2_diff;
    logic             limit_hit;

`ifdef MODINV_ITER_LIMIT_EN
    localparam int             CNT_W = $clog2(4*WIDTH+8);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(4*WIDTH+4);
    logic [CNT_W-1:0] iter_cnt;

    // Count RUN cycles since the last accepted start as a guard against corrupted state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            iter_cnt <= '0;
        end else if (state == IDLE) begin
            iter_cnt <= '0;
        end else if (state == RUN && iter_cnt != LIMIT) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end

    assign limit_hit = (state == RUN) && (iter_cnt == LIMIT);
`else
    assign limit_hit = 1'b0;
`endif

    // Halving and subtraction candidates for x1/x2, using one extra bit so x+n cannot overflow
    always_comb begin
        x1_sum  = {1'b0, x1} + {1'b0, n_q};
        x2_sum  = {1'b0, x2} + {1'b0, n_q};
        x1_half = x1[0] ? (x1_sum >> 1) : ({1'b0, x1} >> 1);
        x2_half = x2[0] ? (x2_sum >> 1) : ({1'b0, x2} >> 1);
        x1_diff = (x1 >= x2) ? ({1'b0, x1} - {1'b0, x2}) : (x1_sum - {1'b0, x2});
        x2_diff = (x2 >= x1) ? ({1'b0, x2} - {1'b0, x1}) : (x2_sum - {1'b0, x1});
    end

    // Control FSM: latch operands on start, take one Euclid step per RUN cycle, report in DONE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            u          <= '0;
            v          <= '0;
            x1         <= '0;
            x2         <= '0;
            n_q        <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            o_result   <= '0;
            o_finished <= 1'b0;
            o_error    <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_finished <= 1'b0;
                    if (i_start) begin
                        o_result <= '0;
                        o_error  <= 1'b0;
                        o_busy   <= 1'b1;
                        n_q      <= i_n;
                        u        <= i_a;
                        v        <= i_n;
                        x1       <= WIDTH'(1);
                        x2       <= '0;
                        res_q    <= '0;
                        if (!i_n[0] || i_a == '0 || i_a >= i_n) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (limit_hit) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else if (u == WIDTH'(1)) begin
                        res_q <= x1;
                        state <= DONE;
                    end else if (v == WIDTH'(1)) begin
                        res_q <= x2;
                        state <= DONE;
                    end else if (u == '0 || v == '0) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= x1_half[WIDTH-1:0];
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= x2_half[WIDTH-1:0];
                    end else if (u >= v) begin
                        u  <= u - v;
                        x1 <= x1_diff[WIDTH-1:0];
                    end else begin
                        v  <= v - u;
                        x2 <= x2_diff[WIDTH-1:0];
                    end
                end
                DONE: begin
                    o_finished <= 1'b1;
                    o_error    <= err_q;
                    o_result   <= err_q ? '0 : res_q;
                    o_busy     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
